// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: fetch FSM states and the IF/ID register layout.
// Used by the fetch stage and by the decoder side of the IF/ID boundary.
package rv32i_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    // Bubble entry: canonical NOP (addi x0,x0,0) with zeroed PC fields.
    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, inst: NOP_INST, valid: 1'b0};

endpackage

// File: rtl/rv32i_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold; one-cycle latency.
// Hold is the stall/backpressure path: nothing changes while neither bubble nor load is asserted.
module rv32i_if_id_reg
    import rv32i_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t entry_i,
    output if_id_t entry_o
);

    if_id_t entry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= IF_ID_BUBBLE;
        end else if (bubble_i) begin
            entry_q <= IF_ID_BUBBLE;
        end else if (load_i) begin
            entry_q <= entry_i;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/rv32i_fetch_stage.sv
// RV32I fetch stage: PC register, RUN/HALT FSM, redirect with one bubble; fetch latency one cycle.
// Stall freezes PC and IF/ID indefinitely; halt parks the PC until resume.
module rv32i_fetch_stage
    import rv32i_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_halt,
    input  logic             i_resume,
    output logic [WIDTH-1:0] o_addr,
    input  logic [WIDTH-1:0] i_inst,
    output logic [WIDTH-1:0] o_if_pc,
    output logic [WIDTH-1:0] o_if_pc4,
    output logic [WIDTH-1:0] o_if_inst,
    output logic             o_if_valid,
    output logic             o_halted
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] redirect_target;
    logic             if_load;
    logic             if_bubble;
    if_id_t           if_entry_d;
    if_id_t           if_entry_q;

    assign pc_plus4        = pc_q + WIDTH'(4);
    assign redirect_target = i_redirect_pc & ~WIDTH'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_load   = 1'b0;
        if_bubble = 1'b0;
        case (state_q)
            FETCH_RUN: begin
                if (i_redirect) begin
                    pc_d      = redirect_target;
                    if_bubble = 1'b1;
                end else if (i_halt) begin
                    state_d   = FETCH_HALT;
                    if_bubble = 1'b1;
                end else if (!i_stall) begin
                    pc_d    = pc_plus4;
                    if_load = 1'b1;
                end
            end
            FETCH_HALT: begin
                // IF/ID already holds a bubble; only the PC and the state can move here.
                if (i_redirect) begin
                    pc_d = redirect_target;
                end
                if (i_resume) begin
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase
    end

    assign if_entry_d = '{pc: pc_q, pc4: pc_plus4, inst: i_inst, valid: 1'b1};

    rv32i_if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (if_load),
        .bubble_i (if_bubble),
        .entry_i  (if_entry_d),
        .entry_o  (if_entry_q)
    );

    assign o_addr     = pc_q;
    assign o_if_pc    = if_entry_q.pc;
    assign o_if_pc4   = if_entry_q.pc4;
    assign o_if_inst  = if_entry_q.inst;
    assign o_if_valid = if_entry_q.valid;
    assign o_halted   = (state_q == FETCH_HALT);

endmodule
